// File: rtl/pf_mem_req_queue.sv
// rtl/pf_mem_req_queue.sv - in-order prefetch request queue with L2/L3 issue ports and shared credit limit
// Optional build macro: PF_MEM_REQ_MERGE_EN (merge a request identical to the most recently written entry)
module pf_mem_req_queue #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int MAX_OUTST = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_v_i,
    input  logic              req_l2_i,
    input  logic              req_l3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              req_rdy_o,
    output logic              l2_req_v_o,
    output logic [ADDR_W-1:0] l2_req_addr_o,
    input  logic              l2_req_rdy_i,
    output logic              l3_req_v_o,
    output logic [ADDR_W-1:0] l3_req_addr_o,
    input  logic              l3_req_rdy_i,
    input  logic              l2_rsp_v_i,
    input  logic              l3_rsp_v_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [2:0]        outst_o,
    output logic              err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_CREDIT
    } state_t;

    // Each entry is {lvl, addr}; lvl=1 selects the L3 port.
    logic [ADDR_W:0] mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic [2:0]      outst;
    logic [2:0]      outst_nxt;
    logic [3:0]      outst_sum;
    logic [1:0]      rsp_cnt;
    logic            underflow;
    logic            err;
    state_t          state;

    logic [ADDR_W:0] head;
    logic [ADDR_W:0] req_entry;
    logic            issue;
    logic            accept;
    logic            merge;
    logic            enq;
    logic            deq;

    assign full_o    = (count == CW'(DEPTH));
    assign empty_o   = (count == '0);
    assign req_rdy_o = ~full_o;
    assign outst_o   = outst;
    assign err_o     = err;

    assign head          = mem[rptr];
    assign l2_req_addr_o = head[ADDR_W-1:0];
    assign l3_req_addr_o = head[ADDR_W-1:0];

    // Valids come straight from the registered state; reset masks them so nothing issues while rst is high.
    assign issue      = (state == S_ISSUE) & ~rst;
    assign l2_req_v_o = issue & ~head[ADDR_W];
    assign l3_req_v_o = issue & head[ADDR_W];
    assign deq        = (l2_req_v_o & l2_req_rdy_i) | (l3_req_v_o & l3_req_rdy_i);

    // L3 wins when both level bits are set; a request with neither bit is an L1 hit and is dropped.
    assign req_entry = {req_l3_i, req_addr_i};
    assign accept    = req_v_i & req_rdy_o & (req_l2_i | req_l3_i);

`ifdef PF_MEM_REQ_MERGE_EN
    logic [ADDR_W:0] last_entry;
    assign last_entry = mem[wptr - PW'(1)];
    // The last written entry is only leaving this cycle when it is also the head.
    assign merge = ~empty_o & (req_entry == last_entry) & ~(deq & (count == CW'(1)));
`else
    assign merge = 1'b0;
`endif

    assign enq = accept & ~merge;

    // Next-state occupancy and credit count; issue and responses net out, saturating at zero.
    always_comb begin
        count_nxt = count;
        rsp_cnt   = 2'b00;
        outst_sum = 4'd0;
        underflow = 1'b0;
        outst_nxt = outst;
        count_nxt = count + {{(CW-1){1'b0}}, enq} - {{(CW-1){1'b0}}, deq};
        rsp_cnt   = {1'b0, l2_rsp_v_i} + {1'b0, l3_rsp_v_i};
        outst_sum = {1'b0, outst} + {3'b000, deq};
        underflow = (outst_sum < {2'b00, rsp_cnt});
        outst_nxt = underflow ? 3'd0 : 3'(outst_sum - {2'b00, rsp_cnt});
    end

    // Entry storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            mem[wptr] <= req_entry;
        end
    end

    // Pointers, occupancy, credit counter and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            outst <= 3'd0;
            err   <= 1'b0;
        end else begin
            if (enq) begin
                wptr <= wptr + PW'(1);
            end
            if (deq) begin
                rptr <= rptr + PW'(1);
            end
            count <= count_nxt;
            outst <= outst_nxt;
            if (underflow) begin
                err <= 1'b1;
            end
        end
    end

    // Issue FSM; decisions look at next-cycle count and credits so a same-cycle response keeps issue going.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (count_nxt != '0) begin
                        state <= (outst_nxt < 3'(MAX_OUTST)) ? S_ISSUE : S_WAIT_CREDIT;
                    end
                end
                S_ISSUE: begin
                    if (deq) begin
                        if (count_nxt == '0) begin
                            state <= S_IDLE;
                        end else if (outst_nxt >= 3'(MAX_OUTST)) begin
                            state <= S_WAIT_CREDIT;
                        end
                    end
                end
                S_WAIT_CREDIT: begin
                    if (outst_nxt < 3'(MAX_OUTST)) begin
                        state <= (count_nxt != '0) ? S_ISSUE : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pf_mem_req_queue.md
Name: pf_mem_req_queue

Overview:
Sits directly downstream of the prefetch memory-address decode stage. It accepts classified prefetch requests (L2 or L3), buffers them in order, and issues them to the L2 or L3 request port with a valid/ready handshake. A shared credit counter limits the number of in-flight requests.

Parameters:
DEPTH, 4, number of queue entries; power of 2, minimum 2.
ADDR_W, 8, request address width; matches the decode-stage operand width.
MAX_OUTST, 3, maximum number of issued requests awaiting response; range 1..7.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active-high.
req_v_i  in  1  upstream request valid; this is the decode-stage request valid.
req_l2_i  in  1  request targets L2.
req_l3_i  in  1  request targets L3.
req_addr_i  in  ADDR_W  prefetch address.
req_rdy_o  out  1  queue can accept a request; equals ~full_o.
l2_req_v_o  out  1  L2 request valid.
l2_req_addr_o  out  ADDR_W  L2 request address.
l2_req_rdy_i  in  1  L2 accepts the request.
l3_req_v_o  out  1  L3 request valid.
l3_req_addr_o  out  ADDR_W  L3 request address.
l3_req_rdy_i  in  1  L3 accepts the request.
l2_rsp_v_i  in  1  one L2 response returned this cycle.
l3_rsp_v_i  in  1  one L3 response returned this cycle.
full_o  out  1  queue holds DEPTH entries.
empty_o  out  1  queue holds 0 entries.
outst_o  out  3  in-flight request count.
err_o  out  1  sticky error: response received while outst_o is 0 (both counts).

Behaviour:
- Reset (synchronous, rst=1 on a rising edge):
  - read and write pointers, entry count, outst_o, err_o and FSM are all cleared; FSM goes to IDLE.
  - Outputs after reset: empty_o=1, full_o=0, req_rdy_o=1, l2/l3_req_v_o=0, outst_o=0, err_o=0.
  - Reset mid-operation discards all entries and credits; no request issues on the cycle rst is high.
- Enqueue fires when req_v_i & req_rdy_o & (req_l2_i | req_l3_i).
  - Entry stored = {lvl, addr}, with lvl=1 for L3.
  - If both req_l2_i and req_l3_i are set, the entry is L3 (L3 has priority).
  - req_v_i with neither level set (an L1 hit) is consumed and dropped: no enqueue, no state change.
- No bypass path. An entry written at cycle N is presented at the head no earlier than cycle N+1.
- Full queue: req_rdy_o=0. An enqueue and a dequeue on the same cycle when full does not admit the new request.
- Empty queue: both request valids are 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate count of log2(DEPTH)+1 bits gives full/empty.
- Head issue:
  - l2_req_v_o = ISSUE state & head.lvl==0.
  - l3_req_v_o = ISSUE state & head.lvl==1.
  - Both address outputs carry head.addr. At most one request valid is high per cycle.
  - Once asserted, a valid and its address hold stable until the handshake completes.
- Dequeue fires on (l2_req_v_o & l2_req_rdy_i) | (l3_req_v_o & l3_req_rdy_i). The head pops and outst_o increments.
- Credit counter:
  - Decrement = l2_rsp_v_i + l3_rsp_v_i (0..2), saturating at 0.
  - Decrementing below 0 sets err_o. err_o clears only on rst.
  - Issue and response on the same cycle net out arithmetically, e.g. +1 and -1 leaves the count unchanged.
- FSM:
  - IDLE: empty. Go to ISSUE when count>0 and outst_o<MAX_OUTST; go to WAIT_CREDIT when count>0 and outst_o==MAX_OUTST.
  - ISSUE: valids driven. After a dequeue, go to IDLE if the queue becomes empty, otherwise go to WAIT_CREDIT if next outst==MAX_OUTST.
  - WAIT_CREDIT: valids 0. Go to ISSUE when next outst<MAX_OUTST.
  - The transition decision uses next-state count and outst values. A response in the same cycle as the final credit issue allows ISSUE to continue.
- Latency: empty queue with credits available gives request valid 1 cycle after the enqueue cycle.

Optional Feature:
PF_MEM_REQ_MERGE_EN:
- With the macro defined, an accepted request is merged (dropped, no enqueue) when:
  - the queue is non-empty, and
  - its {lvl, addr} equals the most recently written entry, and
  - that entry is not being dequeued in the same cycle.
- req_rdy_o is unchanged by the merge.
- Without the macro, every accepted L2/L3 request is enqueued.

Test Plan:
- Reset, then idle: empty_o=1, req_rdy_o=1, outst_o=0, err_o=0, both request valids 0.
- Enqueue L2 addr 0x10 at cycle 1 with l2_req_rdy_i=1: l2_req_v_o=1 and l2_req_addr_o=0x10 at cycle 2; outst_o=1 at cycle 3.
- Enqueue L3 0x20, L2 0x21, L3 0x22, L2 0x23, then a fifth request while ready is held low: full_o=1, req_rdy_o=0, fifth request not stored; issue order 0x20, 0x21, 0x22; after 3 issues with no responses the FSM sits in WAIT_CREDIT with valids 0; one l3_rsp_v_i pulse allows 0x23 to issue.
- Request with req_l2_i=req_l3_i=0 at 0x30: no enqueue, empty_o stays 1. Request with both bits set at 0x31: issued on the L3 port.
- l2_rsp_v_i pulse with outst_o=0: err_o=1 persists until rst; outst_o stays 0. Then rst high for 1 cycle mid-queue with 2 entries: empty_o=1 and err_o=0 next cycle.
- PF_MEM_REQ_MERGE_EN defined, two back-to-back L2 0x40 requests while the head is stalled: one entry stored. Macro undefined: two entries stored and two issues seen.
